// File: rtl/instruction_prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage: default widths,
// FIFO depth and a saturating-increment helper for the flush counter.
package instruction_prefetch_pkg;

    localparam int PF_ADDR_WIDTH      = 16;
    localparam int PF_INSTR_WIDTH     = 28;
    localparam int PF_DEFAULT_DEPTH   = 4;
    localparam int PF_FLUSH_CNT_WIDTH = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PF_FLUSH_CNT_WIDTH-1:0] sat_inc(
        input logic [PF_FLUSH_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + PF_FLUSH_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/instruction_prefetch_fetch_fifo.sv
// Small circular buffer of {address, instruction} entries. A flush clears
// pointers and count in one cycle; storage contents are left as-is.
module instruction_prefetch_fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);

    // Next-state: flush wins, otherwise independent push/pop bookkeeping.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // State registers, all cleared by reset so the head reads zero.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction fetch stage: owns the PC, fetches one ROM word per cycle into
// the fetch FIFO while there is room, and redirects on a taken branch.
// Optional feature macro: PREFETCH_FLUSH_CNT_EN adds the oFlushCount port
// (saturating count of cycles with iBranchTaken asserted).
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = PF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = PF_INSTR_WIDTH,
    parameter int DEPTH       = PF_DEFAULT_DEPTH
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oRomAddress,
    input  logic [INSTR_WIDTH-1:0] iRomInstruction,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic [ADDR_WIDTH-1:0]  oInstrAddress,
    output logic                   oValid,
    input  logic                   iReady,
    output logic                   oFull
`ifdef PREFETCH_FLUSH_CNT_EN
    ,
    output logic [PF_FLUSH_CNT_WIDTH-1:0] oFlushCount
`endif
);
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [EW-1:0]         head;
    logic                  pop, push;

    // Valid depends only on stored count, so iReady never reaches oValid.
    assign pop         = oValid & iReady;
    assign push        = ~iBranchTaken & (~oFull | pop);
    assign oRomAddress = pc_q;

    // PC: branch target has priority, otherwise advance on each push.
    always_comb begin
        pc_d = pc_q;
        if (iBranchTaken)  pc_d = iBranchTarget;
        else if (push)     pc_d = pc_q + ADDR_WIDTH'(1);
    end

    // PC register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    instruction_prefetch_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .flush (iBranchTaken),
        .wdata ({pc_q, iRomInstruction}),
        .rdata (head),
        .valid (oValid),
        .full  (oFull)
    );

    assign oInstrAddress = head[EW-1:INSTR_WIDTH];
    assign oInstruction  = head[INSTR_WIDTH-1:0];

`ifdef PREFETCH_FLUSH_CNT_EN
    logic [PF_FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Count redirect cycles, sticking at the maximum.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (iBranchTaken) flush_cnt_d = sat_inc(flush_cnt_q);
    end

    // Flush counter register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) flush_cnt_q <= '0;
        else        flush_cnt_q <= flush_cnt_d;
    end

    assign oFlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: a fixed vector table for fill/drain/branch,
// hand-written corner sequences, then randomized traffic, all checked against
// a queue-based model of the fetch buffer.
module tb_instruction_prefetch;
    localparam int DEPTH = 4;

    logic        Clock;
    logic        Reset;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [27:0] oInstruction;
    logic [15:0] oInstrAddress;
    logic        oValid;
    logic        iReady;
    logic        oFull;
`ifdef PREFETCH_FLUSH_CNT_EN
    logic [15:0] oFlushCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [15:0] mq[$];
    logic [15:0] mpc;
    int          mfc;

    function automatic logic [27:0] rom(input logic [15:0] a);
        return {~a[11:0], a};
    endfunction

    assign iRomInstruction = rom(oRomAddress);

    instruction_prefetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .DEPTH(DEPTH)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .oRomAddress     (oRomAddress),
        .iRomInstruction (iRomInstruction),
        .iBranchTaken    (iBranchTaken),
        .iBranchTarget   (iBranchTarget),
        .oInstruction    (oInstruction),
        .oInstrAddress   (oInstrAddress),
        .oValid          (oValid),
        .iReady          (iReady),
        .oFull           (oFull)
`ifdef PREFETCH_FLUSH_CNT_EN
        ,
        .oFlushCount     (oFlushCount)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        rdy;
        logic        br;
        logic [15:0] tgt;
        logic        ev;
        logic [15:0] ea;
        logic        ef;
        logic [15:0] er;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 16'h0000;
        mfc = 0;
    endtask

    task automatic check_model();
        chk("valid", 64'(oValid), 64'(mq.size() != 0));
        chk("full", 64'(oFull), 64'(mq.size() == DEPTH));
        chk("rom_addr", 64'(oRomAddress), 64'(mpc));
        if (mq.size() != 0) begin
            chk("head_addr", 64'(oInstrAddress), 64'(mq[0]));
            chk("head_instr", 64'(oInstruction), 64'(rom(mq[0])));
        end
`ifdef PREFETCH_FLUSH_CNT_EN
        chk("flush_cnt", 64'(oFlushCount), 64'(mfc));
`endif
    endtask

    // Apply inputs just after the falling edge and check state-driven outputs.
    task automatic drive(input logic rdy, input logic br, input logic [15:0] tgt);
        iReady        = rdy;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        #1;
        check_model();
    endtask

    // Clock the DUT once and advance the model with the same inputs.
    task automatic advance(input logic rdy, input logic br, input logic [15:0] tgt);
        logic pop;
        pop = (mq.size() != 0) && rdy;
        @(posedge Clock);
        if (br) begin
            mq.delete();
            mpc = tgt;
            if (mfc < 65535) mfc++;
        end else begin
            if (pop) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(mpc);
                mpc = mpc + 16'd1;
            end
        end
        @(negedge Clock);
    endtask

    task automatic step(input logic rdy, input logic br, input logic [15:0] tgt);
        drive(rdy, br, tgt);
        advance(rdy, br, tgt);
    endtask

    initial begin
        // rdy br tgt | valid addr full rom
        tbl[0]  = '{0, 0, 16'h0,  0, 16'h0000, 0, 16'h0000};
        tbl[1]  = '{0, 0, 16'h0,  1, 16'h0000, 0, 16'h0001};
        tbl[2]  = '{0, 0, 16'h0,  1, 16'h0000, 0, 16'h0002};
        tbl[3]  = '{0, 0, 16'h0,  1, 16'h0000, 0, 16'h0003};
        tbl[4]  = '{0, 0, 16'h0,  1, 16'h0000, 1, 16'h0004};
        tbl[5]  = '{0, 0, 16'h0,  1, 16'h0000, 1, 16'h0004};
        tbl[6]  = '{0, 0, 16'h0,  1, 16'h0000, 1, 16'h0004};
        tbl[7]  = '{0, 0, 16'h0,  1, 16'h0000, 1, 16'h0004};
        tbl[8]  = '{1, 0, 16'h0,  1, 16'h0000, 1, 16'h0004};
        tbl[9]  = '{1, 0, 16'h0,  1, 16'h0001, 1, 16'h0005};
        tbl[10] = '{1, 0, 16'h0,  1, 16'h0002, 1, 16'h0006};
        tbl[11] = '{1, 0, 16'h0,  1, 16'h0003, 1, 16'h0007};
        tbl[12] = '{1, 0, 16'h0,  1, 16'h0004, 1, 16'h0008};
        tbl[13] = '{0, 1, 16'h20, 1, 16'h0005, 1, 16'h0009};
        tbl[14] = '{0, 0, 16'h0,  0, 16'h0000, 0, 16'h0020};
        tbl[15] = '{1, 0, 16'h0,  1, 16'h0020, 0, 16'h0021};
        tbl[16] = '{1, 0, 16'h0,  1, 16'h0021, 0, 16'h0022};

        Reset         = 1'b0;
        iReady        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'h0;
        model_reset();
        repeat (2) @(negedge Clock);
        chk("rst_valid", 64'(oValid), 64'd0);
        chk("rst_full", 64'(oFull), 64'd0);
        chk("rst_rom_addr", 64'(oRomAddress), 64'd0);
        chk("rst_instr", 64'(oInstruction), 64'd0);
        chk("rst_iaddr", 64'(oInstrAddress), 64'd0);
        Reset = 1'b1;

        // fill, stall, drain, branch when full
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
            chk($sformatf("tbl%0d_valid", i), 64'(oValid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_full", i), 64'(oFull), 64'(tbl[i].ef));
            chk($sformatf("tbl%0d_rom", i), 64'(oRomAddress), 64'(tbl[i].er));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_addr", i), 64'(oInstrAddress), 64'(tbl[i].ea));
                chk($sformatf("tbl%0d_instr", i), 64'(oInstruction), 64'(rom(tbl[i].ea)));
            end
            advance(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
        end

        // branch and pop in the same cycle: head 0x0005 consumed, then target
        step(0, 1, 16'h0005);
        step(0, 0, 16'h0);
        drive(1, 1, 16'h0040);
        chk("bp_head", 64'(oInstrAddress), 64'h5);
        chk("bp_valid", 64'(oValid), 64'd1);
        advance(1, 1, 16'h0040);
        drive(1, 0, 16'h0);
        chk("bp_bubble", 64'(oValid), 64'd0);
        advance(1, 0, 16'h0);
        drive(1, 0, 16'h0);
        chk("bp_target", 64'(oInstrAddress), 64'h40);
        advance(1, 0, 16'h0);
        drive(1, 0, 16'h0);
        chk("bp_next", 64'(oInstrAddress), 64'h41);
        advance(1, 0, 16'h0);

        // PC wrap at the top of the address space
        step(0, 1, 16'hFFFF);
        step(1, 0, 16'h0);
        drive(1, 0, 16'h0);
        chk("wrap_ffff", 64'(oInstrAddress), 64'hFFFF);
        advance(1, 0, 16'h0);
        drive(1, 0, 16'h0);
        chk("wrap_0000", 64'(oInstrAddress), 64'h0000);
        chk("wrap_valid", 64'(oValid), 64'd1);
        advance(1, 0, 16'h0);

        // asynchronous reset mid-fill, between clock edges
        repeat (3) step(0, 0, 16'h0);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(oValid), 64'd0);
        chk("mid_rst_full", 64'(oFull), 64'd0);
        chk("mid_rst_rom", 64'(oRomAddress), 64'd0);
        chk("mid_rst_instr", 64'(oInstruction), 64'd0);
        chk("mid_rst_iaddr", 64'(oInstrAddress), 64'd0);
`ifdef PREFETCH_FLUSH_CNT_EN
        chk("mid_rst_fc", 64'(oFlushCount), 64'd0);
`endif
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();

        // three branches
        repeat (3) step(1, 1, 16'h0100);
`ifdef PREFETCH_FLUSH_CNT_EN
        #1 chk("fc_three", 64'(oFlushCount), 64'd3);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, b;
            logic [15:0] t;
            r = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                              : 16'($urandom);
            step(r, b, t);
        end

`ifdef PREFETCH_FLUSH_CNT_EN
        // drive the flush counter into saturation
        iReady = 1'b1;
        iBranchTaken = 1'b1;
        iBranchTarget = 16'h0200;
        while (mfc < 65535) advance(1, 1, 16'h0200);
        drive(1, 1, 16'h0200);
        chk("fc_sat", 64'(oFlushCount), 64'hFFFF);
        advance(1, 1, 16'h0200);
        drive(1, 0, 16'h0);
        chk("fc_sat_hold", 64'(oFlushCount), 64'hFFFF);
        advance(1, 0, 16'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
# instruction_prefetch

Instruction fetch stage that sits directly upstream of the MiniAlu execute/decode stage. It drives the instruction ROM address, buffers fetched 28-bit instruction words together with their addresses in a small FIFO, and presents them to the ALU with a valid/ready handshake. A taken branch from the ALU flushes the buffer and redirects fetch to the branch target.

## Interface
Parameters:
- ADDR_WIDTH, 16, instruction address / PC width
- INSTR_WIDTH, 28, instruction word width
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- Clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- oRomAddress  out  ADDR_WIDTH  fetch address to instruction ROM (equals PC register)
- iRomInstruction  in  INSTR_WIDTH  ROM word for oRomAddress, combinational same-cycle read
- iBranchTaken  in  1  redirect request from ALU
- iBranchTarget  in  ADDR_WIDTH  redirect address, sampled when iBranchTaken=1
- oInstruction  out  INSTR_WIDTH  FIFO head instruction
- oInstrAddress  out  ADDR_WIDTH  address of FIFO head instruction
- oValid  out  1  FIFO head holds a valid entry
- iReady  in  1  consumer accepts head this cycle
- oFull  out  1  FIFO count == DEPTH
- oFlushCount  out  16  only with PREFETCH_FLUSH_CNT_EN

## Operation
- State: PC register, FIFO storage (DEPTH entries of {address, instruction}), write pointer, read pointer, count (0..DEPTH).
- pop = oValid & iReady.
- push = !iBranchTaken & (count < DEPTH | pop). On push, entry {PC, iRomInstruction} written at write pointer; PC <= PC+1.
- count <= count + push - pop; pointers increment mod DEPTH (natural wrap of log2(DEPTH)-bit pointers).
- Branch (iBranchTaken=1): count <= 0, both pointers <= 0, PC <= iBranchTarget, no push that cycle. A pop in the same cycle is consumed by the consumer; all other entries discarded. Branch has priority over everything.
- PC arithmetic modulo 2^ADDR_WIDTH: 0xFFFF+1 wraps to 0x0000.
- Full: push only if a pop occurs the same cycle (simultaneous push+pop keeps count at DEPTH). Empty: oValid=0, oInstruction/oInstrAddress show stale storage, not checked by bench.
- oValid = (count != 0); oFull = (count == DEPTH); oInstruction/oInstrAddress read combinationally from storage at read pointer.
- Reset (asserted at any time, including mid-fill or mid-branch): immediately PC=0, count=0, pointers=0, storage=0, oValid=0, oFull=0, oRomAddress=0, oInstruction=0, oInstrAddress=0, oFlushCount=0.

## Timing
- Fetch latency: instruction at address A fetched in cycle n appears at FIFO head earliest in cycle n+1 (oValid=1 one cycle after reset release or branch).
- Throughput: one instruction per cycle sustained with iReady held high.
- Branch penalty: branch in cycle n → oValid=0 in n+1, target instruction at head with oValid=1 in n+2.
- oRomAddress changes only on clock edges or asynchronous reset.
- No combinational path from iReady to oValid; iBranchTaken affects only next-state.

## Configuration
- PREFETCH_FLUSH_CNT_EN defined: 16-bit oFlushCount port present, incremented by 1 on every cycle with iBranchTaken=1, saturating at 0xFFFF, reset to 0.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared definitions header (alongside opcode defines): instruction width, address width, default FIFO depth constants.
- One sub-module: fetch_fifo (storage, pointers, count, flush input); PC and push/branch control stay in the top.

## Test plan
- Reset release, iReady=1, ROM word = address: oValid rises cycle 1, oInstrAddress/oInstruction sequence 0x0000,0x0001,0x0002… one per cycle.
- iReady=0 for 8 cycles from reset: count reaches 4, oFull=1, oRomAddress holds 0x0004; iReady=1 → heads 0,1,2,3,4 on consecutive cycles, no gap or duplicate.
- FIFO full, iBranchTaken=1 target 0x0020: next cycle oValid=0, oFull=0; following cycle oInstrAddress=0x0020, then 0x0021.
- Branch and pop same cycle with head 0x0005: 0x0005 consumed once, next valid head 0x0040 (target), no entry 0x0006.
- PC at 0xFFFF, iReady=1: heads 0xFFFF then 0x0000.
- Reset asserted mid-fill between edges: all outputs zero immediately; with PREFETCH_FLUSH_CNT_EN, 3 branches → oFlushCount=3, counter forced to 0xFFFF stays 0xFFFF on further branch.
